// File: rtl/led_chain_sequencer_if.sv
// Bus bundle between the register/host side, the frame sequencer and the
// serial bit driver. The sequencer uses the slave view; the host-side logic
// that writes colours, requests frames and returns driver done uses the
// master view.
interface led_chain_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [23:0]      wr_color;
  logic             refresh;
  logic             busy;
  logic             frame_done;
  logic             timeout_err;
  logic [23:0]      drv_color;
  logic             drv_start;
  logic             drv_done;

  modport master (
    output wr_en, wr_addr, wr_color, refresh, drv_done,
    input  busy, frame_done, timeout_err, drv_color, drv_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_color, refresh, drv_done,
    output busy, frame_done, timeout_err, drv_color, drv_start
  );
endinterface

// File: rtl/led_chain_sequencer.sv
// Frame sequencer for a daisy chain of serial RGB LEDs. Keeps a colour per
// LED, walks the chain in index order issuing one start/done transaction per
// LED to the bit driver, then holds the line idle for the latch gap and
// pulses frame_done. Refresh requests arriving mid-frame coalesce into one
// follow-up frame.
module led_chain_sequencer #(
  parameter int NUM_LEDS       = 4,
  parameter int IDX_W          = 4,
  parameter int LATCH_CYCLES   = 8000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  led_chain_sequencer_if.slave bus
);
  localparam int LW    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [2:0] {IDLE, LOAD, START, ARM, WAIT, NEXT, LATCH} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic [LW-1:0]    latch_cnt;
  logic [TW-1:0]    tout_cnt;
  logic [23:0]      color [DEPTH];
  logic             wr_ok;

  logic             busy_r;
  logic             frame_done_r;
  logic             timeout_err_r;
  logic             drv_start_r;
  logic [23:0]      drv_color_r;

  assign bus.busy        = busy_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.drv_start   = drv_start_r;
  assign bus.drv_color   = drv_color_r;

  // Entries at or above NUM_LEDS exist only so the index is full width; they
  // are never written and never read by a frame.
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (IDX_W + 1)'(NUM_LEDS));

  // Colour register file: writes land on the edge, in any FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) color[i] <= '0;
    end else if (wr_ok) begin
      color[bus.wr_addr] <= bus.wr_color;
    end
  end

  // Frame FSM with registered outputs: per-LED load/start/arm/wait, then latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      pending       <= 1'b0;
      latch_cnt     <= '0;
      tout_cnt      <= '0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      drv_start_r   <= 1'b0;
      drv_color_r   <= '0;
    end else begin
      drv_start_r  <= 1'b0;
      frame_done_r <= 1'b0;

      // Any colour write acknowledges a previous timeout; a new timeout below wins.
      if (bus.wr_en) timeout_err_r <= 1'b0;

      // Requests while a frame is running fold into a single extra frame;
      // the LATCH exit below clears this when it consumes it.
      if (bus.refresh && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.refresh) begin
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end

        // drv_start is registered here so it is high for exactly the START cycle.
        LOAD: begin
          drv_color_r <= color[idx];
          drv_start_r <= 1'b1;
          state       <= START;
        end

        START: begin
          tout_cnt <= '0;
          state    <= ARM;
        end

        // The driver's done may still be high from the previous LED; skip one sample.
        ARM: state <= WAIT;

        WAIT: begin
          if (bus.drv_done) begin
            state <= NEXT;
          end else if ((TIMEOUT_CYCLES < 2) || (int'(tout_cnt) >= TIMEOUT_CYCLES - 2)) begin
            // Counter would reach TIMEOUT_CYCLES-1: abandon the rest of this frame.
            timeout_err_r <= 1'b1;
            idx           <= '0;
            latch_cnt     <= LW'(LATCH_CYCLES - 1);
            frame_done_r  <= (LATCH_CYCLES < 2);
            state         <= LATCH;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end

        NEXT: begin
          if (idx == IDX_W'(NUM_LEDS - 1)) begin
            idx          <= '0;
            latch_cnt    <= LW'(LATCH_CYCLES - 1);
            frame_done_r <= (LATCH_CYCLES < 2);
            state        <= LATCH;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end

        // frame_done is raised as the count hits 0, so it marks the final
        // latch cycle and the next frame (if any) follows without an IDLE cycle.
        LATCH: begin
          if (latch_cnt == '0) begin
            if (pending || bus.refresh) begin
              pending <= 1'b0;
              state   <= LOAD;
            end else begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            latch_cnt    <= latch_cnt - 1'b1;
            frame_done_r <= (latch_cnt == LW'(1));
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_chain_sequencer.sv
// Directed bench for led_chain_sequencer with a small bit-driver model and a
// colour scoreboard. cyc counts rising edges; everything is sampled one time
// unit after the falling edge, so a value seen with cyc == k was launched by
// rising edge k.
module tb_led_chain_sequencer;
  localparam int NL = 4;
  localparam int IW = 4;
  localparam int LC = 20;
  localparam int TC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_chain_sequencer_if #(.IDX_W(IW)) bus ();

  led_chain_sequencer #(
    .NUM_LEDS(NL), .IDX_W(IW), .LATCH_CYCLES(LC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int start_t[$];
  logic [23:0] exp_q[$];
  logic [23:0] model_col [NL];
  int drv_mode = 0;   // 0: normal driver, 1: driver never answers
  int dcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h (%0d) expected=0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  // Driver model: done stays high after a transfer (stale) until two clocks
  // after it sees start, then rises again five clocks after start.
  always @(negedge clk) begin
    if (drv_mode == 1) begin
      bus.drv_done = 1'b0;
    end else if (bus.drv_start === 1'b1) begin
      dcnt = 5;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 3) bus.drv_done = 1'b0;
      if (dcnt == 0) bus.drv_done = 1'b1;
    end
  end

  // Monitor: every start pops the scoreboard and checks the colour presented.
  always @(negedge clk) begin
    if (bus.drv_start === 1'b1) begin
      start_cnt++;
      start_t.push_back(cyc);
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("drv_color", 32'(bus.drv_color), 32'(exp_q.pop_front()));
    end
    if (bus.frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [23:0] c);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = IW'(a);
    bus.wr_color = c;
    step(1);
    bus.wr_en = 1'b0;
    if (a < NL) model_col[a] = c;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model_col[i]);
  endtask

  // c0 is the cycle the request is driven in; the DUT samples it at edge c0+1.
  task automatic pulse(output int c0);
    c0 = cyc;
    bus.refresh = 1'b1;
    step(1);
    bus.refresh = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_frame_done", 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_drv_start", 32'(start_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fdb, c0, fd1, err_cyc, n;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_color = '0;
    bus.refresh = 1'b0;
    for (int i = 0; i < NL; i++) model_col[i] = '0;
    step(2);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst_drv_start", 32'(bus.drv_start), 32'd0);
    chk("rst_drv_color", 32'(bus.drv_color), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Basic frame: start lands 2 cycles after the request, LEDs 8 cycles apart
    // (5 to done + NEXT/LOAD/START), frame_done 20 cycles after the last done
    // (done seen 6 cycles after its start in cyc terms).
    wr(0, 24'h0FF0A5); wr(1, 24'h123456); wr(2, 24'hABCDEF); wr(3, 24'h000001);
    base = start_cnt; fdb = fd_cnt;
    push_frame(NL);
    pulse(c0);
    chk("t1_busy_after_accept", 32'(bus.busy), 32'd1);
    wait_fd(fdb + 1, 200);
    chk("t1_starts", 32'(start_cnt - base), 32'd4);
    chk("t1_first_start", 32'(start_t[base]), 32'(c0 + 2));
    for (int i = 1; i < NL; i++) chk("t1_gap", 32'(start_t[base+i] - start_t[base+i-1]), 32'd8);
    chk("t1_fd_time", 32'(fd_cyc - start_t[base+3]), 32'd26);
    chk("t1_busy_at_fd", 32'(bus.busy), 32'd1);
    step(1);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);
    chk("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Stale done: the model still holds done high from the last LED.
    step(3);
    chk("t2_stale_done_high", 32'(bus.drv_done), 32'd1);
    base = start_cnt; fdb = fd_cnt;
    push_frame(NL);
    pulse(c0);
    wait_fd(fdb + 1, 200);
    chk("t2_starts", 32'(start_cnt - base), 32'd4);
    chk("t2_first_start", 32'(start_t[base]), 32'(c0 + 2));
    for (int i = 1; i < NL; i++) chk("t2_gap", 32'(start_t[base+i] - start_t[base+i-1]), 32'd8);
    step(1);

    // Pending coalesce: two requests during LED 1 give exactly one extra frame.
    base = start_cnt; fdb = fd_cnt;
    push_frame(NL);
    push_frame(NL);
    pulse(c0);
    wait_start(base + 2, 100);
    pulse(n);
    step(2);
    pulse(n);
    wait_fd(fdb + 1, 300);
    fd1 = fd_cyc;
    step(1);
    chk("t3_busy_across", 32'(bus.busy), 32'd1);
    wait_fd(fdb + 2, 300);
    chk("t3_second_frame_start", 32'(start_t[base+4] - fd1), 32'd2);
    step(1);
    chk("t3_busy_fall", 32'(bus.busy), 32'd0);
    step(40);
    chk("t3_starts", 32'(start_cnt - base), 32'd8);
    chk("t3_frame_dones", 32'(fd_cnt - fdb), 32'd2);

    // Timeout: start is taken by the driver at edge s+1; the error is set 16
    // edges later (s+17), then the 20-cycle latch gap runs.
    drv_mode = 1;
    step(2);
    base = start_cnt; fdb = fd_cnt;
    push_frame(1);
    pulse(c0);
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    err_cyc = cyc;
    chk("t4_err_seen", 32'(bus.timeout_err), 32'd1);
    chk("t4_err_time", 32'(err_cyc - start_t[base]), 32'd17);
    wait_fd(fdb + 1, 100);
    chk("t4_fd_time", 32'(fd_cyc - err_cyc), 32'd19);
    chk("t4_one_start", 32'(start_cnt - base), 32'd1);
    step(1);
    chk("t4_busy_fall", 32'(bus.busy), 32'd0);
    chk("t4_err_sticky", 32'(bus.timeout_err), 32'd1);
    wr(2, 24'h5A5A5A);
    chk("t4_err_cleared", 32'(bus.timeout_err), 32'd0);
    drv_mode = 0;
    step(2);

    // Mid-frame reset during WAIT of LED 2.
    base = start_cnt;
    push_frame(3);
    pulse(c0);
    wait_start(base + 3, 100);
    step(3);
    chk("t5_busy_before_rst", 32'(bus.busy), 32'd1);
    chk("t5_color_before_rst", 32'(bus.drv_color), 32'h5A5A5A);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_drv_start", 32'(bus.drv_start), 32'd0);
    chk("t5_rst_drv_color", 32'(bus.drv_color), 32'd0);
    chk("t5_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    for (int i = 0; i < NL; i++) model_col[i] = '0;
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("t5_no_restart", 32'(start_cnt - base), 32'd3);
    base = start_cnt; fdb = fd_cnt;
    push_frame(NL);
    pulse(c0);
    wait_fd(fdb + 1, 200);
    chk("t5_starts", 32'(start_cnt - base), 32'd4);
    chk("t5_first_start", 32'(start_t[base]), 32'(c0 + 2));
    step(2);

    // Out-of-range write must not touch any LED.
    wr(0, 24'h111111); wr(1, 24'h222222); wr(2, 24'h333333); wr(3, 24'h444444);
    wr(5, 24'hDEAD00);
    base = start_cnt; fdb = fd_cnt;
    push_frame(NL);
    pulse(c0);
    wait_fd(fdb + 1, 200);
    chk("t6_starts", 32'(start_cnt - base), 32'd4);
    step(2);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_chain_sequencer.md
Name: led_chain_sequencer

Overview:
- Frame sequencer for a daisy-chain of NUM_LEDS serial RGB LEDs driven by one drv_INPI1556FCH instance.
- Holds a per-LED 24-bit colour register file written by the AXI/register side.
- On a refresh request it issues one start/done transaction to the bit driver per LED, in index order 0..NUM_LEDS-1.
- After the last LED it holds the line idle for the latch gap, then reports frame completion.

Parameters:
- NUM_LEDS, 4, LEDs in the chain (2..16).
- IDX_W, 4, width of the LED index (must satisfy 2^IDX_W >= NUM_LEDS).
- LATCH_CYCLES, 8000, clocks of idle after the last LED (80 us at 100 MHz).
- TIMEOUT_CYCLES, 4096, max clocks to wait for drv_done before aborting the LED.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  colour write strobe.
- wr_addr  in  IDX_W  LED index to write; writes with wr_addr >= NUM_LEDS are ignored.
- wr_color  in  24  colour for wr_addr.
- refresh  in  1  frame request; single-cycle pulse or level.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse at end of latch gap.
- timeout_err  out  1  sticky; set on a driver timeout, cleared by reset or by wr_en.
- drv_color  out  24  to driver color; registered, stable through each transaction.
- drv_start  out  1  to driver start; one-cycle pulse.
- drv_done  in  1  from driver done.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; idx=0; pending=0.
  - Outputs: busy=0, frame_done=0, timeout_err=0, drv_start=0, drv_color=0.
  - All colour registers are cleared to 0.
  - A reset mid-frame aborts immediately; drv_start is never re-issued for the aborted LED.
- Colour writes:
  - A write takes effect on the clock edge and is accepted in any state.
  - An LED's colour is sampled into drv_color in LOAD. A mid-frame write to an LED not yet loaded appears in the current frame; otherwise it appears in the next frame.
- FSM states: IDLE, LOAD, START, ARM, WAIT, NEXT, LATCH.
  - IDLE: if refresh=1 at edge T, go to LOAD. busy=1 from T+1.
  - LOAD: drv_color <= color[idx]; go to START.
  - START: drv_start=1 for this cycle only; clear the timeout counter; go to ARM.
  - ARM: drv_done is ignored for one cycle, because the driver's done may still be high from the previous LED. Go to WAIT.
  - WAIT:
    - drv_done=1: go to NEXT.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, set timeout_err and go to LATCH; the remaining LEDs in this frame are skipped.
  - NEXT: if idx==NUM_LEDS-1, set idx=0, load the latch counter with LATCH_CYCLES-1, and go to LATCH. Otherwise idx<=idx+1 and go to LOAD.
  - LATCH: count down to 0. At 0, pulse frame_done for one cycle. Then:
    - if pending=1 or refresh=1: clear pending, go to LOAD; busy stays 1, frame_done still pulses.
    - else go to IDLE with busy=0.
- Latency: refresh at edge T gives drv_start at T+2 and the first drv_done sample at T+4.
- Inter-LED gap: done sampled at edge D gives the next drv_start at D+3 (NEXT, LOAD, START).
- refresh while busy: sets pending; multiple requests coalesce into one extra frame.
- refresh in the same cycle as frame_done: starts the next frame directly; no IDLE cycle.
- drv_color holds its value outside LOAD; it is not cleared between LEDs.
- All counters saturate/compare with no wrap-around. The latch counter width is clog2(LATCH_CYCLES); the timeout counter width is clog2(TIMEOUT_CYCLES).

Test Plan:
- Basic frame, NUM_LEDS=4, LATCH_CYCLES=20, with a bench driver model: write colours 0x0FF0A5, 0x123456, 0xABCDEF, 0x000001 to idx 0..3, pulse refresh.
  - Exactly 4 drv_start pulses.
  - drv_color at each start equals the written colour, in order.
  - frame_done pulses 20 clocks after the 4th done.
  - busy falls the cycle after frame_done.
- Stale done: driver model holds done=1 while idle, pulse refresh.
  - ARM masks the stale done.
  - Each LED still waits for its own done.
  - Still 4 starts, no skipped LED.
- Pending coalesce: pulse refresh twice during LED 1 of a frame.
  - Exactly one extra frame follows.
  - busy stays 1 across the boundary.
  - frame_done pulses twice in total.
- Timeout: TIMEOUT_CYCLES=16, driver never asserts done.
  - After 1 start, timeout_err=1 16 clocks later.
  - LATCH is entered and frame_done pulses.
  - A following wr_en clears timeout_err.
- Mid-frame reset: assert rst_n=0 during WAIT of LED 2.
  - busy, drv_start, drv_color and timeout_err go to 0 immediately.
  - After release, refresh starts a new frame at idx 0 with all colours 0.
- Out-of-range write: wr_addr=5 with NUM_LEDS=4.
  - No register changes.
  - The next frame's drv_color values are unchanged.
